// File: rtl/dac_test_pattern_gen.sv
// DAC test pattern generator: programmable-rate sawtooth, triangle, square,
// staircase and constant patterns for exercising a video DAC. A step divider
// paces the waveform; each step produces a one-cycle sample_strobe with a new
// registered sample value.
module dac_test_pattern_gen #(
   parameter int DIV_W = 16
) (
   input  logic       clk27,
   input  logic       rst_n,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [7:0] cfg_wdata,
   output logic [7:0] sample,
   output logic       sample_strobe
);

   // Register map
   localparam logic [1:0] ADDR_MODE   = 2'd0;
   localparam logic [1:0] ADDR_DIV_LO = 2'd1;
   localparam logic [1:0] ADDR_DIV_HI = 2'd2;
   localparam logic [1:0] ADDR_LEVEL  = 2'd3;

   // Waveform modes; codes 5-7 produce a constant zero
   localparam logic [2:0] MODE_SAW    = 3'd0;
   localparam logic [2:0] MODE_TRI    = 3'd1;
   localparam logic [2:0] MODE_SQUARE = 3'd2;
   localparam logic [2:0] MODE_STAIR  = 3'd3;
   localparam logic [2:0] MODE_CONST  = 3'd4;

   // Byte-addressed view of the divider, wide enough for both write bytes
   localparam int EXT_W = (DIV_W > 16) ? DIV_W : 16;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   logic [2:0]       mode_q, mode_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] div_active_q, div_active_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [7:0]       level_q, level_d;
   logic [7:0]       ph_q, ph_d;
   dir_e             dir_q, dir_d;
   logic [7:0]       sample_q, sample_d;
   logic             strobe_q, strobe_d;

   logic [7:0]       ph_adv;
   dir_e             dir_adv;
   logic [7:0]       wave_val;
   logic [EXT_W-1:0] div_ext;
   logic             mode_wr;
   logic             reload;

   // Next phase/direction for one waveform step and the sample it produces
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      ph_adv   = ph_q + 8'd1;
      dir_adv  = dir_q;
      wave_val = 8'd0;

      if (mode_q == MODE_TRI) begin
         if (dir_q == DIR_UP) begin
            if (ph_q == 8'hFF) begin
               ph_adv  = 8'hFE;
               dir_adv = DIR_DOWN;
            end
         end else begin
            if (ph_q == 8'h00) begin
               ph_adv  = 8'h01;
               dir_adv = DIR_UP;
            end else begin
               ph_adv  = ph_q - 8'd1;
            end
         end
      end

      case (mode_q)
         MODE_SAW,
         MODE_TRI:    wave_val = ph_adv;
         MODE_SQUARE: wave_val = ph_adv[7] ? 8'd0 : level_q;
         MODE_STAIR:  wave_val = 8'(ph_adv[7:5]) * 8'd36;
         MODE_CONST:  wave_val = level_q;
         default:     wave_val = 8'd0;
      endcase
   end

   // Divider, restart, waveform advance and register-write next state
   always_comb begin
      mode_d       = mode_q;
      div_d        = div_q;
      div_active_d = div_active_q;
      cnt_d        = cnt_q;
      level_d      = level_q;
      ph_d         = ph_q;
      dir_d        = dir_q;
      sample_d     = sample_q;
      strobe_d     = 1'b0;
      div_ext      = EXT_W'(div_q);

      mode_wr = cfg_we && (cfg_addr == ADDR_MODE);
      reload  = (cnt_q == div_active_q);

      // A mode write restarts the pattern and takes precedence over a step
      if (mode_wr) begin
         mode_d       = cfg_wdata[2:0];
         cnt_d        = '0;
         div_active_d = div_q;
         ph_d         = 8'd0;
         dir_d        = DIR_UP;
         sample_d     = 8'd0;
      end else if (reload) begin
         // New divider values only take effect here, at a period boundary
         cnt_d        = '0;
         div_active_d = div_q;
         ph_d         = ph_adv;
         dir_d        = dir_adv;
         sample_d     = wave_val;
         strobe_d     = 1'b1;
      end else begin
         cnt_d        = cnt_q + DIV_W'(1);
      end

      if (cfg_we) begin
         case (cfg_addr)
            ADDR_DIV_LO: begin
               div_ext[7:0] = cfg_wdata;
               div_d        = div_ext[DIV_W-1:0];
            end
            ADDR_DIV_HI: begin
               div_ext[15:8] = cfg_wdata;
               div_d         = div_ext[DIV_W-1:0];
            end
            ADDR_LEVEL:  level_d = cfg_wdata;
            default:     ;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk27 or negedge rst_n) begin
      if (!rst_n) begin
         mode_q       <= MODE_SAW;
         div_q        <= '0;
         div_active_q <= '0;
         cnt_q        <= '0;
         level_q      <= 8'hFF;
         ph_q         <= 8'd0;
         dir_q        <= DIR_UP;
         sample_q     <= 8'd0;
         strobe_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge state.
         mode_q       <= mode_d;
         div_q        <= div_d;
         div_active_q <= div_active_d;
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         ph_q         <= ph_d;
         dir_q        <= dir_d;
         sample_q     <= sample_d;
         strobe_q     <= strobe_d;
      end
   end

   assign sample        = sample_q;
   assign sample_strobe = strobe_q;

endmodule

// File: doc/dac_test_pattern_gen.md
DAC_TEST_PATTERN_GEN -- requirements
Module: dac_test_pattern_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of the step-divider register.
REQ-002 SHALL have port clk27  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port cfg_we  input  1  register write strobe, one write per cycle.
REQ-005 SHALL have port cfg_addr  input  2  register address (0 mode, 1 div low byte, 2 div high byte, 3 level).
REQ-006 SHALL have port cfg_wdata  input  8  register write data.
REQ-007 SHALL have port sample  output  8  registered DAC code, fed to the video DAC output register.
REQ-008 SHALL have port sample_strobe  output  1  one-cycle pulse in the cycle sample takes a new value.

Function
REQ-009 SHALL hold registers mode[2:0], div[DIV_W-1:0] (bytes beyond DIV_W ignored), div_active, level[7:0], step counter cnt, waveform phase ph[7:0], triangle direction dir (UP/DOWN).
REQ-010 SHALL increment cnt each cycle; when cnt==div_active: cnt<=0, div_active<=div, assert sample_strobe next cycle and advance the waveform once.
REQ-011 SHALL produce a strobe every cycle when div_active==0; strobe period is div_active+1 cycles.
REQ-012 SHALL apply div writes only at the next cnt reload (no mid-period glitch).
REQ-013 SHALL in mode 0 (sawtooth) set sample=ph, ph<=ph+1 per strobe, wrapping 255->0.
REQ-014 SHALL in mode 1 (triangle) count up in UP, down in DOWN; at 255 in UP go to 254 and DOWN; at 0 in DOWN go to 1 and UP; period 510 strobes.
REQ-015 SHALL in mode 2 (square) output level while ph[7]==0 and 0 while ph[7]==1, ph incrementing per strobe (128 strobes each half).
REQ-016 SHALL in mode 3 (staircase) output 36*ph[7:5] (0,36,...,252), ph incrementing per strobe (32 strobes per step, 8 steps).
REQ-017 SHALL in mode 4 (constant) output level, strobes still generated.
REQ-018 SHALL treat modes 5-7 as constant 0.
REQ-019 SHALL on write to mode: ph<=0, dir<=UP, cnt<=0, div_active<=div, sample<=0 next cycle; first strobe div+1 cycles after the write.
REQ-020 SHALL apply level writes immediately; sample reflects new level at the next strobe.
REQ-021 SHALL give mode write priority over a coincident strobe (restart wins, no advance that cycle).
REQ-022 SHALL register sample and sample_strobe; no combinational path from cfg_* to outputs.

Reset
REQ-023 SHALL on rst_n low asynchronously set sample=0, sample_strobe=0, mode=0, div=0, div_active=0, cnt=0, ph=0, dir=UP, level=8'hFF.
REQ-024 SHALL after rst_n release start sawtooth with strobe every cycle (sample 1,2,3,... from first strobe).
REQ-025 SHALL discard any in-progress waveform/divider state on reset assertion mid-operation.

Verification
REQ-026 Reset release, no writes -> sample_strobe high every cycle, sample 1,2,...,255,0,1 wrap.
REQ-027 Write div=3, mode=1 -> strobe every 4 cycles, sample 0,1,...,255,254,...,0,1; 510-strobe period.
REQ-028 Write level=8'h80, mode=2, div=0 -> 128 strobes at 0x80, 128 at 0x00, repeating.
REQ-029 mode=3, div=0 -> values 0,36,72,...,252 each for 32 strobes, then back to 0.
REQ-030 Sawtooth running div=9, write div=2 mid-period -> current period completes at 10 cycles, subsequent periods 3 cycles.
REQ-031 Assert rst_n low mid-triangle DOWN -> sample=0, strobe=0 immediately; after release sawtooth from 1.
